dev_dpdm: RTL and testbench
===========================

// Module: dev_dpdm
// PURPOSE
//  Device-end DP/DM line interface; the peer of the host-side DP/DM block.
//  RX path: detects host SYNC, streams packet bits to the device decoder and
//  checks EOP. TX path: serializes the device response (SYNC, bits, EOP, J).
//  Sits between the bus lines and the device unencoding/encoding pipelines.
// PARAMETERS
//  LEN_W        7    width of tx_len (bit count incl. stuffed bits)
//  MAX_RX_BITS  100  RX timeout limit in bit cycles; used only with the macro
// PORTS
//  clk          in   1      system clock, one bit per cycle
//  rst_b        in   1      asynchronous active-low reset
//  dp_in,dm_in  in   1,1    line state from host
//  dp_out,dm_out out 1,1    line state driven by device
//  oe           out  1      device owns the bus (dp_out/dm_out valid on bus)
//  rx_bit       out  1      received bit (= dp_in)
//  rx_valid     out  1      rx_bit valid this cycle
//  rx_done      out  1      1-cycle pulse: good EOP seen
//  rx_err       out  1      1-cycle pulse: bad EOP / SE1 / timeout
//  tx_start     in   1      request to send, sampled in IDLE only
//  tx_len       in   LEN_W  bits to send, latched on accepted tx_start
//  tx_bit       in   1      next TX bit, sampled while tx_bit_req=1
//  tx_bit_req   out  1      block consumes tx_bit this cycle
//  tx_busy      out  1      state != IDLE and transmitting
//  tx_done      out  1      1-cycle pulse on the final J cycle
// BEHAVIOUR
//  - Line states: J=(1,0) K=(0,1) SE0=(0,0) SE1=(1,1).
//  - Reset (async): state IDLE, sync count 0, oe=0, dp_out=1, dm_out=0, all
//    pulses/valids 0. Reset mid-operation aborts immediately, no done pulses.
//  - FSM: IDLE, RX_DATA, RX_EOP, TX_SYNC, TX_DATA, TX_EOP, TX_J.
//  - IDLE: drives J, oe=0. Sync counter matches K J K J K J K K; mismatch
//    clears count to 0. 8th match -> RX_DATA next cycle. tx_start with
//    tx_len!=0 wins over sync search (count cleared) -> TX_SYNC next cycle.
//    tx_start with tx_len==0 is ignored. tx_start outside IDLE ignored.
//  - RX_DATA: non-SE0, non-SE1 -> rx_valid=1, rx_bit=dp_in. SE0 -> RX_EOP,
//    rx_valid=0. SE1 -> rx_err pulse, IDLE.
//  - RX_EOP (one SE0 already seen): SE0 -> stay, increment SE0 count.
//    J with total SE0 >= 2 -> rx_done pulse that cycle, IDLE.
//    J with total SE0 == 1, or K/SE1 -> rx_err pulse, IDLE.
//  - TX_SYNC: 8 cycles driving K J K J K J K K, oe=1.
//  - TX_DATA: tx_len cycles, tx_bit_req=1, dp_out=tx_bit, dm_out=~tx_bit.
//  - TX_EOP: 2 cycles SE0. TX_J: 1 cycle J, tx_done pulse -> IDLE.
//  - TX latency: tx_start at cycle n -> first K at n+1; oe high exactly
//    8+tx_len+3 cycles; tx_busy high for the same cycles.
//  - While oe=1 the RX path is inhibited (no rx_valid/rx_done/rx_err).
// CONFIGURATION
//  - DEV_DPDM_RX_TIMEOUT_EN defined: bit counter in RX_DATA; on the cycle
//    it would exceed MAX_RX_BITS valid bits without SE0 -> rx_err pulse,
//    rx_valid=0, IDLE.
//  - Undefined: no counter, RX_DATA waits for SE0/SE1 indefinitely.
// STRUCTURE
//  - Shared package dpdm_pkg: line-state enum {J,K,SE0,SE1}, SYNC pattern
//    constant (K J K J K J K K), EOP_SE0_CYCLES=2, FSM state typedef.
//  - One sub-module: dev_dpdm_sync_det (sync counter + pattern match,
//    clear input, sync_detected output). TX sequencing stays in top.
// TESTING
//  1. SYNC, then dp 1,0,1,1, SE0,SE0,J -> rx_valid 4 cycles, bits 1011;
//     rx_done on J cycle; rx_err never.
//  2. K J K J J ... then full valid SYNC -> no rx_valid until second SYNC;
//     packet then received normally.
//  3. tx_start, tx_len=3, tx_bit 1,0,0 -> oe 14 cycles: KJKJKJKK,(1,0),
//     (0,1),(0,1),SE0,SE0,J; tx_done on J cycle; then oe=0, J.
//  4. SYNC, 2 bits, single SE0 then J -> rx_err pulse, no rx_done.
//  5. rst_b low mid TX_DATA -> oe=0, dp_out=1, dm_out=0 at once; tx_start
//     after release accepted with full SYNC.
//  6. Macro on, MAX_RX_BITS=100: SYNC + 101 J/K bits -> 100 rx_valid, then
//     rx_err; macro off -> 101 rx_valid, no rx_err.

Source files
------------

// File: rtl/dpdm_pkg.sv
// ---------------------------------------------------------------------------
// dpdm_pkg
// Shared definitions for the device-side DP/DM line interface.
//   line_t         : bus line states, encoded as {dp, dm}
//   SYNC_IS_K      : SYNC pattern K J K J K J K K, bit i set when symbol i is K
//   sync_sym()     : SYNC symbol for a given position
//   EOP_SE0_CYCLES : SE0 cycles in a transmitted / required in a received EOP
//   state_t        : line interface FSM states
// ---------------------------------------------------------------------------
package dpdm_pkg;

    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_K   = 2'b01,
        LS_J   = 2'b10,
        LS_SE1 = 2'b11
    } line_t;

    // Symbol order on the wire is bit 0 first: K J K J K J K K
    localparam logic [7:0] SYNC_IS_K = 8'b1101_0101;

    localparam int EOP_SE0_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_DATA,
        ST_RX_EOP,
        ST_TX_SYNC,
        ST_TX_DATA,
        ST_TX_EOP,
        ST_TX_J
    } state_t;

    function automatic line_t sync_sym(input logic [2:0] idx);
        return SYNC_IS_K[idx] ? LS_K : LS_J;
    endfunction

endpackage

// File: rtl/dev_dpdm_sync_det.sv
// ---------------------------------------------------------------------------
// dev_dpdm_sync_det
// Tracks how much of the SYNC pattern has been seen on the host lines.
// Any symbol that does not continue the pattern restarts the search at 0.
//   clk, rst_b        : clock, asynchronous active-low reset
//   clear_i           : force the match count to 0 (not idle / TX accepted)
//   line_i            : current line state from the host
//   sync_detected_o   : eighth consecutive matching symbol seen this cycle
// ---------------------------------------------------------------------------
import dpdm_pkg::*;

module dev_dpdm_sync_det (
    input  logic  clk,
    input  logic  rst_b,
    input  logic  clear_i,
    input  line_t line_i,
    output logic  sync_detected_o
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic       match;

    assign match           = (line_i == sync_sym(cnt_q));
    assign sync_detected_o = !clear_i && match && (cnt_q == 3'd7);

    // Advance on a matching symbol; the count wraps to 0 after the last one
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !match) begin
            cnt_d = 3'd0;
        end else begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dev_dpdm.sv
// ---------------------------------------------------------------------------
// dev_dpdm
// Device-end DP/DM line interface. RX: finds host SYNC, streams packet bits
// and checks the EOP. TX: sends SYNC, tx_len data bits, 2x SE0 and one J.
// Ports:
//   clk, rst_b              : clock (one bit per cycle), async active-low reset
//   dp_in, dm_in            : host line state
//   dp_out, dm_out, oe      : device line drive and bus ownership
//   rx_bit, rx_valid        : received bit (= dp_in) and its qualifier
//   rx_done, rx_err         : good EOP / bad EOP, SE1 or timeout pulses
//   tx_start, tx_len        : send request and bit count (IDLE only)
//   tx_bit, tx_bit_req      : data bit consumed when tx_bit_req is high
//   tx_busy, tx_done        : transmitting / final J cycle pulse
// Configuration:
//   DEV_DPDM_RX_TIMEOUT_EN  : abort RX after MAX_RX_BITS bits without SE0
// LEN_W must be at least 3 (the SYNC position shares the TX counter).
// ---------------------------------------------------------------------------
import dpdm_pkg::*;

module dev_dpdm #(
    parameter int LEN_W       = 7,
    parameter int MAX_RX_BITS = 100
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             dp_in,
    input  logic             dm_in,
    output logic             dp_out,
    output logic             dm_out,
    output logic             oe,
    output logic             rx_bit,
    output logic             rx_valid,
    output logic             rx_done,
    output logic             rx_err,
    input  logic             tx_start,
    input  logic [LEN_W-1:0] tx_len,
    input  logic             tx_bit,
    output logic             tx_bit_req,
    output logic             tx_busy,
    output logic             tx_done
);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] txCnt_q, txCnt_d;
    logic [LEN_W-1:0] txLen_q, txLen_d;
    logic [1:0]       se0Cnt_q, se0Cnt_d;
    line_t            lineIn;
    logic             txAccept;
    logic             syncDetected;
    logic             rxTimeout;

    assign lineIn   = line_t'({dp_in, dm_in});
    assign rx_bit   = dp_in;
    assign txAccept = (state_q == ST_IDLE) && tx_start && (tx_len != '0);

    // A transmit request restarts the SYNC search, as does leaving IDLE
    dev_dpdm_sync_det u_sync_det (
        .clk             (clk),
        .rst_b           (rst_b),
        .clear_i         ((state_q != ST_IDLE) || txAccept),
        .line_i          (lineIn),
        .sync_detected_o (syncDetected)
    );

`ifdef DEV_DPDM_RX_TIMEOUT_EN
    localparam int RXB_W = $clog2(MAX_RX_BITS + 1);

    logic [RXB_W-1:0] rxBits_q, rxBits_d;

    // The next J/K after MAX_RX_BITS valid bits is the timeout cycle
    assign rxTimeout = (rxBits_q == RXB_W'(MAX_RX_BITS));

    always_comb begin
        rxBits_d = rxBits_q;
        if (state_q != ST_RX_DATA) begin
            rxBits_d = '0;
        end else if (rx_valid) begin
            rxBits_d = rxBits_q + RXB_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rxBits_q <= '0;
        end else begin
            rxBits_q <= rxBits_d;
        end
    end
`else
    logic unused_maxRxBits;
    assign unused_maxRxBits = ^MAX_RX_BITS;
    assign rxTimeout        = 1'b0;
`endif

    // Next state and all line/handshake outputs; idle drives J with oe low
    always_comb begin
        state_d    = state_q;
        txCnt_d    = txCnt_q;
        txLen_d    = txLen_q;
        se0Cnt_d   = se0Cnt_q;
        dp_out     = 1'b1;
        dm_out     = 1'b0;
        oe         = 1'b0;
        rx_valid   = 1'b0;
        rx_done    = 1'b0;
        rx_err     = 1'b0;
        tx_bit_req = 1'b0;
        tx_busy    = 1'b0;
        tx_done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                txCnt_d = '0;
                if (txAccept) begin
                    txLen_d = tx_len;
                    state_d = ST_TX_SYNC;
                end else if (syncDetected) begin
                    state_d = ST_RX_DATA;
                end
            end

            ST_RX_DATA: begin
                case (lineIn)
                    LS_J, LS_K: begin
                        if (rxTimeout) begin
                            rx_err  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            rx_valid = 1'b1;
                        end
                    end
                    LS_SE0: begin
                        se0Cnt_d = 2'd1;
                        state_d  = ST_RX_EOP;
                    end
                    default: begin
                        rx_err  = 1'b1;
                        state_d = ST_IDLE;
                    end
                endcase
            end

            // se0Cnt saturates so an over-long EOP still counts as >= 2
            ST_RX_EOP: begin
                case (lineIn)
                    LS_SE0: begin
                        if (se0Cnt_q != 2'd3) begin
                            se0Cnt_d = se0Cnt_q + 2'd1;
                        end
                    end
                    LS_J: begin
                        if (se0Cnt_q >= 2'(EOP_SE0_CYCLES)) begin
                            rx_done = 1'b1;
                        end else begin
                            rx_err = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end
                    default: begin
                        rx_err  = 1'b1;
                        state_d = ST_IDLE;
                    end
                endcase
            end

            ST_TX_SYNC: begin
                oe               = 1'b1;
                tx_busy          = 1'b1;
                {dp_out, dm_out} = sync_sym(txCnt_q[2:0]);
                if (txCnt_q[2:0] == 3'd7) begin
                    txCnt_d = '0;
                    state_d = ST_TX_DATA;
                end else begin
                    txCnt_d = txCnt_q + LEN_W'(1);
                end
            end

            ST_TX_DATA: begin
                oe         = 1'b1;
                tx_busy    = 1'b1;
                tx_bit_req = 1'b1;
                dp_out     = tx_bit;
                dm_out     = ~tx_bit;
                if (txCnt_q == txLen_q - LEN_W'(1)) begin
                    txCnt_d = '0;
                    state_d = ST_TX_EOP;
                end else begin
                    txCnt_d = txCnt_q + LEN_W'(1);
                end
            end

            ST_TX_EOP: begin
                oe      = 1'b1;
                tx_busy = 1'b1;
                dp_out  = 1'b0;
                dm_out  = 1'b0;
                if (txCnt_q == LEN_W'(EOP_SE0_CYCLES - 1)) begin
                    txCnt_d = '0;
                    state_d = ST_TX_J;
                end else begin
                    txCnt_d = txCnt_q + LEN_W'(1);
                end
            end

            ST_TX_J: begin
                oe      = 1'b1;
                tx_busy = 1'b1;
                tx_done = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= ST_IDLE;
            txCnt_q  <= '0;
            txLen_q  <= '0;
            se0Cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            txCnt_q  <= txCnt_d;
            txLen_q  <= txLen_d;
            se0Cnt_q <= se0Cnt_d;
        end
    end

endmodule

// File: tb/tb_dev_dpdm.sv
// ---------------------------------------------------------------------------
// tb_dev_dpdm
// Cycle-stepped bench for dev_dpdm. Each vector holds the host line state,
// TX request inputs and the expected outputs for that cycle. Expected values
// come from scenario builders that expand a packet description (bits, EOP
// length, ending) into per-cycle expectations.
// Expected output word: {dp_out, dm_out, oe, rx_valid, rx_valid&rx_bit,
//                        rx_done, rx_err, tx_bit_req, tx_busy, tx_done}
// ---------------------------------------------------------------------------
module tb_dev_dpdm;

    localparam int MAX_RX = 100;
`ifdef DEV_DPDM_RX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam logic [9:0] E_IDLE  = 10'b10_0000_0000;
    localparam logic [9:0] E_RXERR = 10'b10_0000_1000;
    localparam logic [9:0] E_RXDN  = 10'b10_0001_0000;
    localparam logic [9:0] E_RX1   = 10'b10_0110_0000;
    localparam logic [9:0] E_RX0   = 10'b10_0100_0000;
    localparam logic [9:0] E_TXK   = 10'b01_1000_0010;
    localparam logic [9:0] E_TXJ   = 10'b10_1000_0010;
    localparam logic [9:0] E_TXSE0 = 10'b00_1000_0010;
    localparam logic [9:0] E_TXEND = 10'b10_1000_0011;

    typedef struct packed {
        logic       dp;
        logic       dm;
        logic       ts;
        logic [6:0] len;
        logic       tb;
        logic [9:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       dp_in, dm_in;
    logic       dp_out, dm_out, oe;
    logic       rx_bit, rx_valid, rx_done, rx_err;
    logic       tx_start;
    logic [6:0] tx_len;
    logic       tx_bit;
    logic       tx_bit_req, tx_busy, tx_done;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    int   syncK[8] = '{1, 0, 1, 0, 1, 0, 1, 1};

    always #5 clk = ~clk;

    dev_dpdm #(.LEN_W(7), .MAX_RX_BITS(MAX_RX)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .dp_in      (dp_in),
        .dm_in      (dm_in),
        .dp_out     (dp_out),
        .dm_out     (dm_out),
        .oe         (oe),
        .rx_bit     (rx_bit),
        .rx_valid   (rx_valid),
        .rx_done    (rx_done),
        .rx_err     (rx_err),
        .tx_start   (tx_start),
        .tx_len     (tx_len),
        .tx_bit     (tx_bit),
        .tx_bit_req (tx_bit_req),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    function automatic vec_t mk(input logic dp, input logic dm, input logic ts,
                                input logic [6:0] len, input logic tb,
                                input logic [9:0] exp);
        vec_t v;
        v.dp = dp; v.dm = dm; v.ts = ts; v.len = len; v.tb = tb; v.exp = exp;
        return v;
    endfunction

    task automatic checkOutput(input logic [9:0] exp, input string name, input int idx);
        logic [9:0] got;
        got = {dp_out, dm_out, oe, rx_valid, rx_valid & rx_bit,
               rx_done, rx_err, tx_bit_req, tx_busy, tx_done};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s #%0d: got %b expected %b", name, idx, got, exp);
        end
    endtask

    // Drive one cycle shortly after the edge, sample late in the same cycle
    task automatic applyStimulus(input vec_t v, input string name, input int idx);
        @(posedge clk);
        #1;
        dp_in    = v.dp;
        dm_in    = v.dm;
        tx_start = v.ts;
        tx_len   = v.len;
        tx_bit   = v.tb;
        #6;
        checkOutput(v.exp, name, idx);
    endtask

    task automatic runVecs(input string name);
        foreach (vecs[i]) applyStimulus(vecs[i], name, i);
        vecs.delete();
    endtask

    task automatic addLine(input logic dp, input logic dm);
        vecs.push_back(mk(dp, dm, 1'b0, 7'd0, 1'b0, E_IDLE));
    endtask

    task automatic addIdle(input int n);
        for (int i = 0; i < n; i++) addLine(1'b1, 1'b0);
    endtask

    task automatic addSync(input int n);
        for (int i = 0; i < n; i++) addLine(syncK[i] == 0, syncK[i] == 1);
    endtask

    // endKind: 0 J, 1 K, 2 SE1 after the SE0s, 3 SE1 instead of the EOP
    task automatic addRxPacket(input int nbits, input logic [127:0] bits,
                               input int nSe0, input int endKind);
        bit aborted = 1'b0;
        addSync(8);
        for (int i = 0; i < nbits; i++) begin
            if (aborted) begin
                addLine(bits[i], ~bits[i]);
            end else if (TO_EN && i >= MAX_RX) begin
                vecs.push_back(mk(bits[i], ~bits[i], 1'b0, 7'd0, 1'b0, E_RXERR));
                aborted = 1'b1;
            end else begin
                vecs.push_back(mk(bits[i], ~bits[i], 1'b0, 7'd0, 1'b0,
                                  bits[i] ? E_RX1 : E_RX0));
            end
        end
        if (!aborted && endKind == 3) begin
            vecs.push_back(mk(1'b1, 1'b1, 1'b0, 7'd0, 1'b0, E_RXERR));
        end else begin
            for (int i = 0; i < nSe0; i++) addLine(1'b0, 1'b0);
            if (aborted) begin
                addLine(1'b1, 1'b0);
            end else if (endKind == 0) begin
                vecs.push_back(mk(1'b1, 1'b0, 1'b0, 7'd0, 1'b0,
                                  (nSe0 >= 2) ? E_RXDN : E_RXERR));
            end else if (endKind == 1) begin
                vecs.push_back(mk(1'b0, 1'b1, 1'b0, 7'd0, 1'b0, E_RXERR));
            end else begin
                vecs.push_back(mk(1'b1, 1'b1, 1'b0, 7'd0, 1'b0, E_RXERR));
            end
        end
        addIdle(1);
    endtask

    // Host lines, stray tx_start and tx_bit are random while the device owns the bus
    task automatic addTx(input int len, input logic [127:0] bits);
        logic [1:0] hl;
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 7'(len), 1'b0, E_IDLE));
        for (int i = 0; i < 8 + len + 3; i++) begin
            logic [9:0] e;
            logic       b;
            hl = 2'($urandom_range(0, 3));
            b  = 1'($urandom);
            if (i < 8) begin
                e = syncK[i] ? E_TXK : E_TXJ;
            end else if (i < 8 + len) begin
                b = bits[i - 8];
                e = {b, ~b, 8'b1000_0110};
            end else if (i < 8 + len + 2) begin
                e = E_TXSE0;
            end else begin
                e = E_TXEND;
            end
            vecs.push_back(mk(hl[1], hl[0], 1'($urandom), 7'($urandom_range(0, 127)), b, e));
        end
        addIdle(1);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        vec_t t1[15];
        int   kind;

        rst_b    = 1'b0;
        dp_in    = 1'b1;
        dm_in    = 1'b0;
        tx_start = 1'b0;
        tx_len   = 7'd0;
        tx_bit   = 1'b0;
        #2;
        checkOutput(E_IDLE, "reset", 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;

        // SYNC, bits 1 0 1 1, SE0 SE0 J
        t1[0]  = mk(1'b0, 1'b1, 1'b0, 7'd0, 1'b0, E_IDLE);
        t1[1]  = mk(1'b1, 1'b0, 1'b0, 7'd0, 1'b0, E_IDLE);
        t1[2]  = mk(1'b0, 1'b1, 1'b0, 7'd0, 1'b0, E_IDLE);
        t1[3]  = mk(1'b1, 1'b0, 1'b0, 7'd0, 1'b0, E_IDLE);
        t1[4]  = mk(1'b0, 1'b1, 1'b0, 7'd0, 1'b0, E_IDLE);
        t1[5]  = mk(1'b1, 1'b0, 1'b0, 7'd0, 1'b0, E_IDLE);
        t1[6]  = mk(1'b0, 1'b1, 1'b0, 7'd0, 1'b0, E_IDLE);
        t1[7]  = mk(1'b0, 1'b1, 1'b0, 7'd0, 1'b0, E_IDLE);
        t1[8]  = mk(1'b1, 1'b0, 1'b0, 7'd0, 1'b0, E_RX1);
        t1[9]  = mk(1'b0, 1'b1, 1'b0, 7'd0, 1'b0, E_RX0);
        t1[10] = mk(1'b1, 1'b0, 1'b0, 7'd0, 1'b0, E_RX1);
        t1[11] = mk(1'b1, 1'b0, 1'b0, 7'd0, 1'b0, E_RX1);
        t1[12] = mk(1'b0, 1'b0, 1'b0, 7'd0, 1'b0, E_IDLE);
        t1[13] = mk(1'b0, 1'b0, 1'b0, 7'd0, 1'b0, E_IDLE);
        t1[14] = mk(1'b1, 1'b0, 1'b0, 7'd0, 1'b0, E_RXDN);
        for (int i = 0; i < 15; i++) applyStimulus(t1[i], "rx_basic", i);
        addIdle(2);
        runVecs("rx_basic_tail");

        // Broken SYNC, then a full one and a normal packet
        addLine(1'b0, 1'b1); addLine(1'b1, 1'b0); addLine(1'b0, 1'b1);
        addLine(1'b1, 1'b0); addLine(1'b1, 1'b0);
        addRxPacket(6, 128'b101100, 2, 0);
        runVecs("rx_badsync");

        addTx(3, 128'b001);
        runVecs("tx_len3");

        addRxPacket(2, 128'b10, 1, 0);
        runVecs("rx_short_eop");

        // tx_len of zero is ignored; tx_start wins over a partial SYNC
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 7'd0, 1'b0, E_IDLE));
        addIdle(2);
        addSync(5);
        addTx(2, 128'b01);
        addRxPacket(3, 128'b110, 2, 0);
        runVecs("tx_start_rules");

        // Long packet: 101 bits, timeout behaviour depends on the build
        addRxPacket(101, rnd128(), 2, 0);
        runVecs("rx_long");

        // Reset while in TX_DATA aborts at once, then a fresh TX works
        addTx(5, rnd128());
        for (int i = 0; i < 11; i++) applyStimulus(vecs[i], "tx_pre_reset", i);
        vecs.delete();
        rst_b = 1'b0;
        #1;
        checkOutput(E_IDLE, "reset_async", 0);
        @(posedge clk);
        #1;
        checkOutput(E_IDLE, "reset_hold", 0);
        @(negedge clk);
        rst_b = 1'b1;
        addTx(4, rnd128());
        runVecs("tx_after_reset");

        // Randomized mix of packets and transmissions
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: addRxPacket($urandom_range(1, 30), rnd128(),
                               $urandom_range(1, 3), $urandom_range(0, 2));
                1: addRxPacket($urandom_range(1, 30), rnd128(), 2, 3);
                2: addTx($urandom_range(1, 40), rnd128());
                default: addIdle($urandom_range(1, 3));
            endcase
            runVecs("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
